// File: rtl/conv_feeder_pkg.sv
// conv_feeder_pkg: shared types and lane geometry for the conv stream feeder.
package conv_feeder_pkg;
  localparam int LANES = 4;
  localparam int LANE_WIDTH = 8;
  typedef enum logic [2:0] {IDLE, BIAS, WEIGHTS, PIXELS, DRAIN} feeder_state_t;
  typedef enum logic [1:0] {PH_NONE, PH_BIAS, PH_WEIGHT, PH_PIXEL} phase_t;
endpackage

// File: rtl/conv_feeder_rd_pipe.sv
// conv_feeder_rd_pipe: phase tag stage aligned with memory data, then registered packet and valid decode.
module conv_feeder_rd_pipe
  import conv_feeder_pkg::*;
#(
  parameter int PACKET_WIDTH = LANES * LANE_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  phase_t                  issue_phase,
  input  logic [PACKET_WIDTH-1:0] rd_data,
  output logic [PACKET_WIDTH-1:0] packet,
  output logic                    bias_valid,
  output logic                    weights_valid,
  output logic                    input_valid,
  output logic                    empty
);
  phase_t tag;
  // tag lines up with the cycle the memory presents data, so the packet register is stage 2
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      tag <= PH_NONE;
      packet <= '0;
      bias_valid <= 1'b0;
      weights_valid <= 1'b0;
      input_valid <= 1'b0;
    end else begin
      tag <= issue_phase;
      bias_valid <= tag == PH_BIAS;
      weights_valid <= tag == PH_WEIGHT;
      input_valid <= tag == PH_PIXEL;
      if (tag != PH_NONE) packet <= rd_data;
    end
  assign empty = tag == PH_NONE && !(bias_valid || weights_valid || input_valid);
endmodule

// File: rtl/conv_stream_feeder.sv
// conv_stream_feeder: reads bias, WxW weights and DxD pixels and streams them as packets to the conv layer.
// Define CONV_FEEDER_DRAIN_TIMEOUT_EN to add the DRAIN watchdog (DRAIN_TIMEOUT cycles).
module conv_stream_feeder
  import conv_feeder_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int PACKET_WIDTH = 32,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [7:0]              cfg_input_dim,
  input  logic [1:0]              cfg_window_dim,
  input  logic                    cfg_stride,
  input  logic                    pause,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
  input  logic [PACKET_WIDTH-1:0] mem_rd_data,
  output logic [PACKET_WIDTH-1:0] newDataPacket,
  output logic [7:0]              inputDim,
  output logic [1:0]              windowDim,
  output logic                    stride,
  output logic                    bias_valid,
  output logic                    weights_valid,
  output logic                    input_valid,
  input  logic                    conv_idle,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_error
);
  feeder_state_t state;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [15:0] cnt, wsq, dsq;
  logic issue, last_rd, empty;
  phase_t issue_phase;
`ifdef CONV_FEEDER_DRAIN_TIMEOUT_EN
  logic [31:0] drain_cnt;
`endif
  assign issue = (state == BIAS || state == WEIGHTS || state == PIXELS) && !pause;
  assign issue_phase = !issue ? PH_NONE : state == BIAS ? PH_BIAS : state == WEIGHTS ? PH_WEIGHT : PH_PIXEL;
  assign wsq = {14'b0, windowDim} * {14'b0, windowDim};
  assign dsq = {8'b0, inputDim} * {8'b0, inputDim};
  assign last_rd = state == BIAS || cnt == (state == WEIGHTS ? wsq : dsq) - 16'd1;
  assign mem_rd_en = issue;
  assign mem_rd_addr = rd_ptr;
  assign busy = state != IDLE;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      rd_ptr <= '0;
      cnt <= '0;
      inputDim <= '0;
      windowDim <= '0;
      stride <= 1'b0;
      done <= 1'b0;
      cfg_error <= 1'b0;
`ifdef CONV_FEEDER_DRAIN_TIMEOUT_EN
      drain_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      cfg_error <= 1'b0;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case (state)
        IDLE:
          if (start) begin
            if (cfg_window_dim == 2'd0 || cfg_input_dim < {6'b0, cfg_window_dim}) cfg_error <= 1'b1;
            else begin
              inputDim <= cfg_input_dim;
              windowDim <= cfg_window_dim;
              stride <= cfg_stride;
              rd_ptr <= base_addr;
              cnt <= '0;
              state <= BIAS;
`ifdef CONV_FEEDER_DRAIN_TIMEOUT_EN
              drain_cnt <= '0;
`endif
            end
          end
        BIAS, WEIGHTS, PIXELS:
          if (issue) begin
            cnt <= last_rd ? 16'd0 : cnt + 16'd1;
            if (last_rd) state <= state == BIAS ? WEIGHTS : state == WEIGHTS ? PIXELS : DRAIN;
          end
        DRAIN: begin
`ifdef CONV_FEEDER_DRAIN_TIMEOUT_EN
          drain_cnt <= drain_cnt + 32'd1;
          if (empty && conv_idle) begin
            done <= 1'b1;
            state <= IDLE;
          end else if (drain_cnt == DRAIN_TIMEOUT - 1) begin
            cfg_error <= 1'b1;
            state <= IDLE;
          end
`else
          if (empty && conv_idle) begin
            done <= 1'b1;
            state <= IDLE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  conv_feeder_rd_pipe #(.PACKET_WIDTH(PACKET_WIDTH)) u_pipe (
    .clock(clock),
    .reset(reset),
    .issue_phase(issue_phase),
    .rd_data(mem_rd_data),
    .packet(newDataPacket),
    .bias_valid(bias_valid),
    .weights_valid(weights_valid),
    .input_valid(input_valid),
    .empty(empty)
  );
endmodule

// File: tb/tb_conv_stream_feeder.sv
// tb_conv_stream_feeder: scoreboard bench; address and packet expectations are queued at start and popped on DUT output.
module tb_conv_stream_feeder;
  logic clock = 0, reset = 0, start = 0, cfg_stride = 0, pause = 0, conv_idle = 1;
  logic [15:0] base_addr = 0;
  logic [7:0] cfg_input_dim = 0;
  logic [1:0] cfg_window_dim = 0;
  logic [31:0] mem_rd_data = 0;
  logic mem_rd_en, stride, bias_valid, weights_valid, input_valid, busy, done, cfg_error;
  logic [15:0] mem_rd_addr;
  logic [31:0] newDataPacket;
  logic [7:0] inputDim;
  logic [1:0] windowDim;
  int checks = 0, errors = 0, cyc = 0, start_cyc = 0;
  int nval = 0, rd_n = 0, done_n = 0, err_n = 0, wv_n = 0, w_first = -1, w_last = -1;
  logic [15:0] addr_q[$];
  logic [33:0] pkt_q[$];
  always #5 clock = ~clock;
  conv_stream_feeder #(.DRAIN_TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .cfg_input_dim(cfg_input_dim), .cfg_window_dim(cfg_window_dim), .cfg_stride(cfg_stride),
    .pause(pause), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .newDataPacket(newDataPacket), .inputDim(inputDim), .windowDim(windowDim), .stride(stride),
    .bias_valid(bias_valid), .weights_valid(weights_valid), .input_valid(input_valid),
    .conv_idle(conv_idle), .busy(busy), .done(done), .cfg_error(cfg_error)
  );
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mem_rd_en) mem_rd_data <= {16'h0, mem_rd_addr};
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  always @(negedge clock)
    if (reset) begin
      if (mem_rd_en) begin
        rd_n++;
        if (addr_q.size() == 0) chk("rd_extra", 1, 0);
        else chk("rd_addr", mem_rd_addr, addr_q.pop_front());
      end
      if (bias_valid || weights_valid || input_valid) begin
        chk("onehot", int'(bias_valid) + int'(weights_valid) + int'(input_valid), 1);
        if (pkt_q.size() == 0) chk("pkt_extra", 1, 0);
        else chk("pkt", {bias_valid ? 2'd1 : weights_valid ? 2'd2 : 2'd3, newDataPacket}, pkt_q.pop_front());
        nval++;
        if (bias_valid) begin
          chk("bias_lat", cyc - start_cyc, 3);
          w_first = -1;
          wv_n = 0;
        end
        if (weights_valid) begin
          if (w_first < 0) w_first = cyc;
          w_last = cyc;
          wv_n++;
        end
      end
      if (done) done_n++;
      if (cfg_error) err_n++;
    end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic go(input logic [15:0] b, input logic [7:0] d, input logic [1:0] w);
    int n = 1 + w * w + d * d;
    for (int i = 0; i < n; i++) begin
      logic [15:0] a;
      a = b + 16'(i);
      addr_q.push_back(a);
      pkt_q.push_back({i == 0 ? 2'd1 : i <= w * w ? 2'd2 : 2'd3, 16'h0, a});
    end
    base_addr = b;
    cfg_input_dim = d;
    cfg_window_dim = w;
    cfg_stride = 1;
    start = 1;
    start_cyc = cyc;
    tick();
    start = 0;
  endtask
  task automatic wait_done(input int lim);
    int k = 0;
    while (!done && k < lim) begin
      @(negedge clock);
      k++;
    end
    chk("done_seen", done, 1);
  endtask
  task automatic reject(input logic [7:0] d, input logic [1:0] w);
    cfg_input_dim = d;
    cfg_window_dim = w;
    start = 1;
    tick();
    start = 0;
    chk("rej_err", cfg_error, 1);
    chk("rej_busy", busy, 0);
    tick();
    chk("rej_err_pulse", cfg_error, 0);
  endtask
  initial begin
    int n0, d0, e0, r0, k;
    tick(2);
    chk("rst_ctl", {busy, done, cfg_error, mem_rd_en, bias_valid, weights_valid, input_valid}, 0);
    chk("rst_data", {newDataPacket, inputDim, windowDim, stride, mem_rd_addr}, 0);
    reset = 1;
    tick();
    n0 = nval; d0 = done_n;
    go(16'h0100, 8'd4, 2'd3);
    chk("cfg_latch", {inputDim, windowDim, stride}, {8'd4, 2'd3, 1'b1});
    chk("busy", busy, 1);
    wait_done(200);
    tick();
    chk("done_pulse", done, 0);
    chk("basic_nval", nval - n0, 26);
    chk("basic_done_n", done_n - d0, 1);
    chk("basic_qs", addr_q.size() + pkt_q.size(), 0);
    n0 = nval;
    go(16'h0300, 8'd4, 2'd3);
    tick(3);
    pause = 1;
    tick(5);
    pause = 0;
    wait_done(200);
    tick();
    chk("pause_nval", nval - n0, 26);
    chk("pause_wv", wv_n, 9);
    chk("pause_span", w_last - w_first, 13);
    r0 = rd_n; e0 = err_n;
    reject(8'd4, 2'd0);
    reject(8'd2, 2'd3);
    chk("rej_rd", rd_n - r0, 0);
    chk("rej_err_n", err_n - e0, 2);
    n0 = nval;
    go(16'hFFFE, 8'd1, 2'd1);
    wait_done(100);
    tick();
    chk("wrap_nval", nval - n0, 3);
    chk("wrap_qs", addr_q.size() + pkt_q.size(), 0);
    n0 = nval; d0 = done_n; e0 = err_n;
    conv_idle = 0;
    go(16'h0400, 8'd2, 2'd2);
    k = 0;
    while (nval - n0 < 9 && k < 300) begin
      @(negedge clock);
      #1;
      k++;
    end
    chk("drain_nval", nval - n0, 9);
    tick(50);
    conv_idle = 1;
    chk("drain_hold", done, 0);
    tick();
`ifdef CONV_FEEDER_DRAIN_TIMEOUT_EN
    chk("drain_to_done", done, 0);
    chk("drain_to_err", err_n - e0, 1);
    chk("drain_to_busy", busy, 0);
`else
    chk("drain_done", done, 1);
    tick();
    chk("drain_done_pulse", done, 0);
    chk("drain_done_n", done_n - d0, 1);
`endif
    go(16'h0500, 8'd4, 2'd3);
    k = 0;
    while (!input_valid && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk("mid_pixels", input_valid, 1);
    #2 reset = 0;
    #1 chk("async_rst", {bias_valid, weights_valid, input_valid, busy, done, mem_rd_en}, 0);
    addr_q.delete();
    pkt_q.delete();
    tick(2);
    reset = 1;
    tick();
    n0 = nval; d0 = done_n;
    go(16'h0600, 8'd4, 2'd3);
    wait_done(200);
    tick();
    chk("rerun_nval", nval - n0, 26);
    chk("rerun_done_n", done_n - d0, 1);
    chk("rerun_qs", addr_q.size() + pkt_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_stream_feeder.md
Name: conv_stream_feeder

Overview:
- Transmit-side sequencer for the convolutional layer's packet interface.
- On a start command it reads one bias word, W×W weight words and D×D pixel words from a 1-cycle-latency word memory.
- It drives each word as a 32-bit four-lane packet with the matching bias/weights/input valid strobe, then waits for the layer to go idle and reports done.

Parameters:
- ADDR_WIDTH, 16, memory word-address width.
- PACKET_WIDTH, 32, packet width; four 8-bit lanes, lane n in bits [8n+7:8n].
- DRAIN_TIMEOUT, 1024, watchdog limit in cycles; used only when the optional feature is compiled in.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  address of the bias word.
- cfg_input_dim  in  8  D, the frame edge in pixels.
- cfg_window_dim  in  2  W, the kernel edge.
- cfg_stride  in  1  stride select, forwarded to the layer.
- pause  in  1  when high, suppresses new memory reads.
- mem_rd_en  out  1  read strobe.
- mem_rd_addr  out  ADDR_WIDTH  read address.
- mem_rd_data  in  PACKET_WIDTH  read data, valid the cycle after mem_rd_en.
- newDataPacket  out  PACKET_WIDTH  registered packet to the layer.
- inputDim  out  8  latched D.
- windowDim  out  2  latched W.
- stride  out  1  latched stride.
- bias_valid  out  1  packet is bias.
- weights_valid  out  1  packet is a weight.
- input_valid  out  1  packet is a pixel.
- conv_idle  in  1  AND of the layer's per-lane idle flags.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- cfg_error  out  1  one-cycle pulse: start was rejected or the drain timed out.

Behaviour:
- Reset: every output is 0; the FSM goes to IDLE; all counters clear. Reset asserted mid-job aborts immediately and no done is issued.
- FSM states: IDLE, BIAS, WEIGHTS, PIXELS, DRAIN.
- IDLE:
  - start with W==0 or D<W → cfg_error pulses the next cycle and the FSM stays in IDLE.
  - Otherwise latch base_addr, D, W and stride (inputDim/windowDim/stride update the next cycle), load rd_ptr=base_addr and go to BIAS.
- Read issue:
  - In BIAS, WEIGHTS and PIXELS, each cycle with pause==0 asserts mem_rd_en at rd_ptr and then increments rd_ptr (wraps mod 2^ADDR_WIDTH).
  - BIAS issues 1 read; WEIGHTS issues W*W reads; PIXELS issues D*D reads (16-bit counter).
  - After the last read of a phase, the FSM moves to the next phase in the same cycle that read is issued.
- Packet pipeline:
  - Stage 1 captures mem_rd_data together with a phase tag from the issue cycle.
  - Stage 2 registers newDataPacket and asserts exactly one valid strobe.
  - Issue-to-valid latency is 2 cycles.
  - Valid strobes are mutually exclusive.
  - newDataPacket holds its last value when no valid is asserted.
- pause gates issue only:
  - Reads already issued still emerge 1–2 cycles later.
  - pause held high for N cycles inserts exactly N bubbles into the valid stream.
  - Order and addresses are unchanged.
- Timing without pause (start sampled at cycle 0):
  - rd_en runs cycles 1..1+W²+D².
  - bias_valid at cycle 3.
  - weights_valid at cycles 4..3+W².
  - input_valid for the following D² cycles.
- DRAIN:
  - Entered after the last pixel read.
  - Waits until both pipeline stages are empty, then waits until conv_idle==1 is sampled.
  - Then pulses done and returns to IDLE.
  - If conv_idle is already high when the pipeline empties, done follows on the next cycle.
- start while busy is ignored and is not queued.
- start and pause in the same IDLE cycle: the start is accepted and the first read is held off until pause drops.

Optional Feature:
- Macro: CONV_FEEDER_DRAIN_TIMEOUT_EN.
- Defined: DRAIN counts cycles. If conv_idle has not been seen within DRAIN_TIMEOUT cycles, cfg_error pulses, done is not asserted, and the FSM returns to IDLE.
- Undefined: DRAIN waits indefinitely, and the counter and DRAIN_TIMEOUT logic are absent.

Decomposition:
- Package conv_feeder_pkg holds:
  - feeder_state_t (FSM enum).
  - phase_t (NONE/BIAS/WEIGHT/PIXEL).
  - LANES=4 and LANE_WIDTH=8.
- Sub-module conv_feeder_rd_pipe holds the 2-stage data/phase pipeline and the valid decode.
- The FSM and counters stay in the top module.

Test Plan:
- Basic job, W=3, D=4, base=0x0100, memory word = address: 26 reads over addresses 0x0100–0x0119; bias_valid at cycle 3 with 0x0100; 9 weights_valid carrying 0x0101–0x0109; 16 input_valid carrying 0x010A–0x0119. With conv_idle=1, done pulses once.
- pause high for 5 cycles mid-WEIGHTS: exactly 5 bubbles in the weights_valid run; data sequence unchanged; total valid count still 26.
- Config reject with W=0, and separately W=3, D=2: cfg_error pulses one cycle; busy stays 0; no mem_rd_en asserted.
- Drain hold: conv_idle held 0 for 50 cycles after the last pixel, then 1 → done pulses exactly one cycle later. With the macro defined and DRAIN_TIMEOUT=16, cfg_error pulses instead and done stays 0.
- Address wrap, base=0xFFFE, W=1, D=1: reads at 0xFFFE, 0xFFFF, 0x0000.
- Reset asserted during PIXELS: all valids, busy and done drop to 0 asynchronously. A new start after release runs a full clean job.
